// File: rtl/fir_xifu_ex_simd.sv
// fir_xifu_ex_simd
// ----------------
// Execute stage of the FIR XIFU coprocessor. It sits between the ID stage
// (after the register-file read) and the WB stage.
//   * DOTP : N-lane signed SIMD dot-product-accumulate, result in one cycle.
//   * LW/SW: single-outstanding memory access with post-increment address
//            (base + STRIDE, modulo 2^DATA_W), stalling on grant and response.
// The results go into a registered EX/WB stage with valid/ready flow control.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   clear_i              synchronous pipeline flush
//   valid_i / ready_o    ID->EX handshake (ready_o does not depend on valid_i)
//   instr_i              0=NOP 1=DOTP 2=LW 3=SW
//   id_i, rd_i           instruction id and destination index
//   base_i               memory base address (rs1)
//   op_a_i/op_b_i/op_c_i dotp operands; op_b_i is also the SW store data
//   mem_*                request/response memory interface
//   wb_*                 EX/WB output register with valid/ready
//
// Optional feature
//   FIR_XIFU_EX_SIMD_SAT_EN : when defined, the DOTP sum saturates to signed
//   DATA_W and the extra output wb_sat_o flags saturation. When it is not
//   defined, the sum wraps and wb_sat_o is absent.

module fir_xifu_ex_simd #(
    parameter int DATA_W = 32,
    parameter int ELEM_W = 16,
    parameter int ID_W   = 4,
    parameter int RD_W   = 5,
    parameter int STRIDE = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [1:0]          instr_i,
    input  logic [ID_W-1:0]     id_i,
    input  logic [RD_W-1:0]     rd_i,
    input  logic [DATA_W-1:0]   base_i,
    input  logic [DATA_W-1:0]   op_a_i,
    input  logic [DATA_W-1:0]   op_b_i,
    input  logic [DATA_W-1:0]   op_c_i,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [DATA_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [ID_W-1:0]     mem_id_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [1:0]          wb_instr_o,
    output logic [ID_W-1:0]     wb_id_o,
    output logic [RD_W-1:0]     wb_rd_o,
    output logic [DATA_W-1:0]   wb_result_o,
    output logic [DATA_W-1:0]   wb_ldata_o
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
    ,
    output logic                wb_sat_o
`endif
);

    localparam int NLANES = DATA_W / ELEM_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int SUM_W  = DATA_W + NLANES + 1;
    // The low DATA_W bits of the sum do not depend on the bits above them,
    // so the wrapping build only keeps DATA_W bits of accumulator.
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
    localparam int ACC_W  = SUM_W;
`else
    localparam int ACC_W  = DATA_W;
`endif

    localparam logic [1:0] INSTR_NOP  = 2'd0;
    localparam logic [1:0] INSTR_DOTP = 2'd1;
    localparam logic [1:0] INSTR_LW   = 2'd2;
    localparam logic [1:0] INSTR_SW   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state, state_next;

    // Captured LW/SW request
    logic [ID_W-1:0]   req_id;
    logic [RD_W-1:0]   req_rd;
    logic [DATA_W-1:0] req_base;
    logic [DATA_W-1:0] req_wdata;
    logic              req_store;

    logic accept;
    logic capture;
    logic dotp_done;
    logic mem_done;

    // Dot-product datapath
    logic [ELEM_W-1:0]        lane_a, lane_b;
    logic signed [PROD_W-1:0] ext_a, ext_b, prod;
    logic [ACC_W-1:0]         acc;
    logic [DATA_W-1:0]        dotp_res;
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
    logic                     dotp_sat;
    logic [ACC_W-DATA_W:0]    acc_top;
`endif

    assign ready_o = (state == S_IDLE) && (!wb_valid_o || wb_ready_i);
    assign accept  = valid_i && ready_o && (instr_i != INSTR_NOP);

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        ext_a  = '0;
        ext_b  = '0;
        prod   = '0;
        acc    = ACC_W'(signed'(op_c_i));
        for (int unsigned k = 0; k < NLANES; k++) begin
            lane_a = op_a_i[k*ELEM_W +: ELEM_W];
            lane_b = op_b_i[k*ELEM_W +: ELEM_W];
            ext_a  = PROD_W'(signed'(lane_a));
            ext_b  = PROD_W'(signed'(lane_b));
            prod   = ext_a * ext_b;
            acc    = acc + ACC_W'(prod);
        end
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
        // Fits in DATA_W only if every bit from DATA_W-1 upwards is a sign copy.
        acc_top  = acc[ACC_W-1:DATA_W-1];
        dotp_sat = !((&acc_top) || (~|acc_top));
        if (dotp_sat) begin
            dotp_res = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            dotp_res = acc[DATA_W-1:0];
        end
`else
        dotp_res = acc[DATA_W-1:0];
`endif
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        dotp_done  = 1'b0;
        mem_done   = 1'b0;
        if (clear_i) begin
            // A response that was already granted must still be absorbed,
            // unless it arrives together with the flush.
            case (state)
                S_REQ:   state_next = (mem_ready_i && !mem_rvalid_i) ? S_DRAIN : S_IDLE;
                S_WAIT,
                S_DRAIN: state_next = mem_rvalid_i ? S_IDLE : S_DRAIN;
                default: state_next = S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (instr_i == INSTR_DOTP) begin
                            dotp_done = 1'b1;
                        end else begin
                            capture    = 1'b1;
                            state_next = S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        if (mem_rvalid_i) begin
                            mem_done   = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        mem_done   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mem_rvalid_i) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_valid_o = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        mem_id_o    = '0;
        if (state == S_REQ) begin
            mem_valid_o = 1'b1;
            mem_addr_o  = req_base;
            mem_we_o    = req_store;
            mem_be_o    = '1;
            mem_wdata_o = req_store ? req_wdata : '0;
            mem_id_o    = req_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            req_id      <= '0;
            req_rd      <= '0;
            req_base    <= '0;
            req_wdata   <= '0;
            req_store   <= 1'b0;
            wb_valid_o  <= 1'b0;
            wb_instr_o  <= '0;
            wb_id_o     <= '0;
            wb_rd_o     <= '0;
            wb_result_o <= '0;
            wb_ldata_o  <= '0;
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
            wb_sat_o    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (capture) begin
                req_id    <= id_i;
                req_rd    <= rd_i;
                req_base  <= base_i;
                req_wdata <= op_b_i;
                req_store <= (instr_i == INSTR_SW);
            end
            if (clear_i) begin
                wb_valid_o  <= 1'b0;
                wb_instr_o  <= '0;
                wb_id_o     <= '0;
                wb_rd_o     <= '0;
                wb_result_o <= '0;
                wb_ldata_o  <= '0;
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
                wb_sat_o    <= 1'b0;
`endif
            end else if (dotp_done) begin
                wb_valid_o  <= 1'b1;
                wb_instr_o  <= INSTR_DOTP;
                wb_id_o     <= id_i;
                wb_rd_o     <= rd_i;
                wb_result_o <= dotp_res;
                wb_ldata_o  <= '0;
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
                wb_sat_o    <= dotp_sat;
`endif
            end else if (mem_done) begin
                wb_valid_o  <= 1'b1;
                wb_instr_o  <= req_store ? INSTR_SW : INSTR_LW;
                wb_id_o     <= req_id;
                wb_rd_o     <= req_rd;
                wb_result_o <= req_base + DATA_W'(STRIDE);
                wb_ldata_o  <= req_store ? '0 : mem_rdata_i;
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
                wb_sat_o    <= 1'b0;
`endif
            end else if (wb_ready_i) begin
                wb_valid_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_xifu_ex_simd.sv
// Directed testbench for fir_xifu_ex_simd (default parameters).
// Inputs change 1 time unit after the rising edge; registered outputs are
// sampled right then, combinational outputs 1 time unit after the inputs move.

module tb_fir_xifu_ex_simd;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        valid;
    logic        ready;
    logic [1:0]  instr;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] base;
    logic [31:0] op_a, op_b, op_c;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_id;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_instr;
    logic [3:0]  wb_id;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] wb_ldata;
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
    logic        wb_sat;
`endif

    int passed = 0;
    int total  = 0;

    fir_xifu_ex_simd #(
        .DATA_W (32),
        .ELEM_W (16),
        .ID_W   (4),
        .RD_W   (5),
        .STRIDE (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .valid_i      (valid),
        .ready_o      (ready),
        .instr_i      (instr),
        .id_i         (id),
        .rd_i         (rd),
        .base_i       (base),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .op_c_i       (op_c),
        .mem_valid_o  (mem_valid),
        .mem_ready_i  (mem_ready),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_id_o     (mem_id),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .wb_valid_o   (wb_valid),
        .wb_ready_i   (wb_ready),
        .wb_instr_o   (wb_instr),
        .wb_id_o      (wb_id),
        .wb_rd_o      (wb_rd),
        .wb_result_o  (wb_result),
        .wb_ldata_o   (wb_ldata)
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
        ,
        .wb_sat_o     (wb_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; valid = 1'b0; instr = 2'd0;
        id = '0; rd = '0; base = '0; op_a = '0; op_b = '0; op_c = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b1;

        // Reset
        tick(); tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        rst = 1'b0;

        // DOTP 1: 2*4 + 3*5 + 10 = 33
        valid = 1'b1; instr = 2'd1; id = 4'd3; rd = 5'd7;
        op_a = 32'h0003_0002; op_b = 32'h0005_0004; op_c = 32'd10;
        #1;
        chk("dotp1_ready", 32'(ready), 32'd1);
        tick();
        chk("dotp1_valid", 32'(wb_valid), 32'd1);
        chk("dotp1_result", wb_result, 32'd33);
        chk("dotp1_id", 32'(wb_id), 32'd3);
        chk("dotp1_rd", 32'(wb_rd), 32'd7);
        chk("dotp1_instr", 32'(wb_instr), 32'd1);
        chk("dotp1_ldata", wb_ldata, 32'd0);
        chk("dotp1_no_mem", 32'(mem_valid), 32'd0);

        // DOTP 2 back-to-back: 1*3 + (-1)*2 = 1
        op_a = 32'hFFFF_0001; op_b = 32'h0002_0003; op_c = 32'd0; id = 4'd4;
        tick();
        valid = 1'b0;
        chk("dotp2_valid", 32'(wb_valid), 32'd1);
        chk("dotp2_result", wb_result, 32'd1);
        chk("dotp2_id", 32'(wb_id), 32'd4);
        tick();
        chk("dotp2_drained", 32'(wb_valid), 32'd0);

        // Overflow: two lanes of (-32768)^2 = 2^31
        valid = 1'b1; instr = 2'd1;
        op_a = 32'h8000_8000; op_b = 32'h8000_8000; op_c = 32'd0;
        tick();
        valid = 1'b0;
`ifdef FIR_XIFU_EX_SIMD_SAT_EN
        chk("ovf_result", wb_result, 32'h7FFF_FFFF);
        chk("ovf_sat", 32'(wb_sat), 32'd1);
`else
        chk("ovf_result", wb_result, 32'h8000_0000);
`endif
        tick();

        // LW with two stall cycles before grant, response one cycle later
        valid = 1'b1; instr = 2'd2; id = 4'd5; rd = 5'd9; base = 32'h0000_1000;
        tick();
        valid = 1'b0; instr = 2'd0;
        chk("lw_req0_valid", 32'(mem_valid), 32'd1);
        chk("lw_req0_addr", mem_addr, 32'h0000_1000);
        chk("lw_req0_we", 32'(mem_we), 32'd0);
        chk("lw_req0_be", 32'(mem_be), 32'hF);
        chk("lw_req0_id", 32'(mem_id), 32'd5);
        chk("lw_req0_ready", 32'(ready), 32'd0);
        tick();
        chk("lw_req1_valid", 32'(mem_valid), 32'd1);
        chk("lw_req1_addr", mem_addr, 32'h0000_1000);
        chk("lw_req1_ready", 32'(ready), 32'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("lw_req2_addr", mem_addr, 32'h0000_1000);
        chk("lw_req2_we", 32'(mem_we), 32'd0);
        chk("lw_req2_ready", 32'(ready), 32'd0);
        tick();
        mem_ready = 1'b0;
        chk("lw_wait_mem_valid", 32'(mem_valid), 32'd0);
        chk("lw_wait_ready", 32'(ready), 32'd0);
        chk("lw_wait_wb_valid", 32'(wb_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("lw_wb_valid", 32'(wb_valid), 32'd1);
        chk("lw_wb_result", wb_result, 32'h0000_1004);
        chk("lw_wb_ldata", wb_ldata, 32'hDEAD_BEEF);
        chk("lw_wb_instr", 32'(wb_instr), 32'd2);
        chk("lw_wb_rd", 32'(wb_rd), 32'd9);
        chk("lw_ready_back", 32'(ready), 32'd1);

        // SW with address wrap, grant and response in the same cycle
        valid = 1'b1; instr = 2'd3; id = 4'd6; rd = 5'd2;
        base = 32'hFFFF_FFFC; op_b = 32'hA5A5_A5A5;
        tick();
        valid = 1'b0; instr = 2'd0;
        chk("sw_mem_valid", 32'(mem_valid), 32'd1);
        chk("sw_mem_we", 32'(mem_we), 32'd1);
        chk("sw_mem_addr", mem_addr, 32'hFFFF_FFFC);
        chk("sw_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        chk("sw_wb_valid", 32'(wb_valid), 32'd1);
        chk("sw_wb_result", wb_result, 32'h0000_0000);
        chk("sw_wb_ldata", wb_ldata, 32'h0000_0000);
        chk("sw_wb_instr", 32'(wb_instr), 32'd3);
        chk("sw_mem_idle", 32'(mem_valid), 32'd0);
        tick();

        // Backpressure: DOTP A (=4) then DOTP B (=13) with WB stalled
        wb_ready = 1'b0;
        valid = 1'b1; instr = 2'd1; id = 4'd1;
        op_a = 32'h0001_0001; op_b = 32'h0002_0002; op_c = 32'd0;
        #1;
        chk("bp_a_ready", 32'(ready), 32'd1);
        tick();
        id = 4'd2; op_a = 32'h0002_0002; op_b = 32'h0003_0003; op_c = 32'd1;
        #1;
        chk("bp_a_result", wb_result, 32'd4);
        chk("bp_stall1_ready", 32'(ready), 32'd0);
        tick();
        chk("bp_stall2_result", wb_result, 32'd4);
        chk("bp_stall2_valid", 32'(wb_valid), 32'd1);
        chk("bp_stall2_ready", 32'(ready), 32'd0);
        tick();
        chk("bp_stall3_result", wb_result, 32'd4);
        chk("bp_stall3_id", 32'(wb_id), 32'd1);
        chk("bp_stall3_ready", 32'(ready), 32'd0);
        wb_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ready), 32'd1);
        tick();
        valid = 1'b0; instr = 2'd0;
        chk("bp_b_valid", 32'(wb_valid), 32'd1);
        chk("bp_b_result", wb_result, 32'd13);
        chk("bp_b_id", 32'(wb_id), 32'd2);
        tick();
        chk("bp_drained", 32'(wb_valid), 32'd0);

        // Flush while the request is still waiting for grant: request dropped
        valid = 1'b1; instr = 2'd2; base = 32'h0000_3000;
        tick();
        valid = 1'b0; instr = 2'd0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_req_mem_valid", 32'(mem_valid), 32'd0);
        chk("clr_req_ready", 32'(ready), 32'd1);

        // Flush one cycle after LW grant: response drained, no writeback
        valid = 1'b1; instr = 2'd2; base = 32'h0000_2000;
        tick();
        valid = 1'b0; instr = 2'd0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        clear = 1'b1;
        #1;
        chk("flush_wait_ready", 32'(ready), 32'd0);
        tick();
        clear = 1'b0;
        chk("flush_drain_ready", 32'(ready), 32'd0);
        chk("flush_drain_wb_valid", 32'(wb_valid), 32'd0);
        chk("flush_drain_mem_valid", 32'(mem_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("flush_done_wb_valid", 32'(wb_valid), 32'd0);
        chk("flush_done_ldata", wb_ldata, 32'd0);
        chk("flush_done_ready", 32'(ready), 32'd1);

        // DOTP after the flush completes normally
        valid = 1'b1; instr = 2'd1; id = 4'd8;
        op_a = 32'h0003_0002; op_b = 32'h0005_0004; op_c = 32'd10;
        tick();
        valid = 1'b0; instr = 2'd0;
        chk("post_flush_valid", 32'(wb_valid), 32'd1);
        chk("post_flush_result", wb_result, 32'd33);
        chk("post_flush_id", 32'(wb_id), 32'd8);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
